lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit sitting directly upstream of the word-only data memory in the MIPS datapath. It converts ALU byte addresses plus load/store opcodes into word-aligned memory accesses. Sub-word stores are performed as a two-cycle read-modify-write, because memory writes only full words. Loaded words are lane-extracted and sign/zero-extended for write-back, and misaligned accesses are suppressed and counted.

## Interface
- No parameters; data path fixed at 32 bits, byte-addressed, little-endian.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  memory-stage request present; CPU holds all request inputs stable while stall=1.
- op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- addr  in  32  byte address from ALU.
- wdata  in  32  store source (rt); low byte/halfword used for SB/SH.
- pc  in  32  PC of the requesting instruction.
- stall  out  1  CPU must not advance this cycle.
- dm_addr  out  32  word address to memory, {addr[31:2],2'b00}.
- dm_wdata  out  32  full word to write.
- dm_write  out  1  memory write enable (memory writes on rising edge).
- dm_read  out  1  memory read enable.
- dm_rdata  in  32  memory read data, combinational from dm_addr.
- dm_wpc  out  32  PC forwarded for the memory write log.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data is valid this cycle.
- misalign  out  1  current request is misaligned (combinational).
- misalign_cnt  out  8  saturating count of misaligned requests.

## Operation
- States: IDLE, WRITE.
- Lane selection: byte k = addr[1:0] is bits [8k+7:8k]; halfword h = addr[1] is bits [16h+15:16h].
- Misalignment: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; byte ops never misalign.
  - A misaligned request makes no memory access: dm_read=0, dm_write=0, load_valid=0, stall=0.
  - misalign=1 whenever req_valid is high in IDLE and the request is misaligned.
  - misalign_cnt increments once per such cycle and saturates at 255.
- Loads (IDLE, aligned): dm_read=1 and load_valid=1 in the same cycle.
  - LW: load_data = dm_rdata.
  - LH/LB: load_data = selected lane, sign-extended.
  - LHU/LBU: load_data = selected lane, zero-extended.
  - Single cycle; stall=0.
- SW (IDLE, aligned): dm_write=1, dm_wdata=wdata, same cycle; stall=0; stay IDLE.
- SH/SB (IDLE, aligned), read cycle: dm_read=1, stall=1.
  - Register merge word = dm_rdata with the selected lane replaced by wdata[15:0] or wdata[7:0].
  - Latch word address and pc; go to WRITE.
- WRITE: dm_write=1, dm_wdata=merge register, dm_addr and dm_wpc from latches, stall=0; return to IDLE.
  - Inputs are ignored in WRITE (they still carry the held request).
- dm_wpc = pc in IDLE, latched pc in WRITE.
- req_valid=0 in IDLE: all enables 0, stall=0, no state change.

## Timing
- Reset values: state IDLE, merge register 0, latched address and pc 0, misalign_cnt 0.
- While reset=1: stall=0, dm_write=0, dm_read=0, load_valid=0, misalign=0. Outputs are forced regardless of state.
- Reset during WRITE abandons the pending merge: no write occurs, and the FSM is IDLE the next cycle.
- Latency:
  - Loads, SW and misaligned requests: 0 extra cycles.
  - SH/SB: exactly 1 stall cycle, with the write committed at the end of the second cycle.
- Back-to-back: a new request is accepted in the cycle after WRITE. A load immediately after a sub-word store to the same word reads the merged value.
- Outputs in IDLE are combinational from the inputs; outputs in WRITE come from registers only.

## Test plan
- Reset, then LW addr=0x10 with memory[0x10]=0x8899AABB -> load_valid=1, load_data=0x8899AABB, stall=0; misalign_cnt=0.
- LB addr=0x13 and LBU addr=0x13 on word 0x8899AABB -> load_data 0xFFFFFF88 and 0x00000088. LH addr=0x12 -> 0xFFFF8899.
- SB addr=0x21, wdata=0x123456CD on word 0x11223344:
  - cycle 1: stall=1, dm_read=1;
  - cycle 2: dm_write=1, dm_wdata=0x1122CD44, dm_addr=0x20.
  - A following LW 0x20 returns 0x1122CD44.
- SH addr=0x22, wdata=0xBEEF on word 0x11223344 -> written word 0xBEEF3344 after one stall cycle.
- Misaligned LW at 0x11 and SH at 0x23 -> misalign=1 each cycle, no dm_read/dm_write, misalign_cnt=2. After 300 misaligned cycles, misalign_cnt=255.
- Assert reset during WRITE of an SB -> dm_write stays 0, the memory word is unchanged, and state is IDLE after reset drops.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit between the MIPS memory stage and a word-only data memory.
// Sub-word stores become a read-modify-write: a stalled read cycle, then a registered write cycle.
module lsu_align (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  output logic        o_stall,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  output logic        o_dm_write,
  output logic        o_dm_read,
  input  logic [31:0] i_dm_rdata,
  output logic [31:0] o_dm_wpc,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_misalign,
  output logic [7:0]  o_misalign_cnt
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      r_state;
  logic [31:0] r_merge;
  logic [31:0] r_waddr;
  logic [31:0] r_wpc;
  logic [7:0]  r_misalign_cnt;

  logic        w_misaligned;
  logic        w_subword_store;
  logic [4:0]  w_byte_shift;
  logic [4:0]  w_half_shift;
  logic [31:0] w_byte_lane;
  logic [31:0] w_half_lane;
  logic [31:0] w_merge;
  logic [31:0] w_word_addr;

  assign w_word_addr     = {i_addr[31:2], 2'b00};
  assign w_byte_shift    = {i_addr[1:0], 3'b000};
  assign w_half_shift    = {i_addr[1], 4'b0000};
  assign w_byte_lane     = i_dm_rdata >> w_byte_shift;
  assign w_half_lane     = i_dm_rdata >> w_half_shift;
  assign w_subword_store = (i_op == OP_SH) || (i_op == OP_SB);

  always_comb begin
    w_misaligned = 1'b0;
    case (i_op)
      OP_LW, OP_SW:         w_misaligned = (i_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: w_misaligned = i_addr[0];
      default:              w_misaligned = 1'b0;
    endcase
  end

  // Replace the addressed lane of the current memory word with the store data.
  always_comb begin
    w_merge = i_dm_rdata;
    if (i_op == OP_SB)
      w_merge = (i_dm_rdata & ~(32'h0000_00FF << w_byte_shift))
              | ({24'h0, i_wdata[7:0]} << w_byte_shift);
    else if (i_op == OP_SH)
      w_merge = (i_dm_rdata & ~(32'h0000_FFFF << w_half_shift))
              | ({16'h0, i_wdata[15:0]} << w_half_shift);
  end

  always_comb begin
    o_stall      = 1'b0;
    o_dm_write   = 1'b0;
    o_dm_read    = 1'b0;
    o_load_valid = 1'b0;
    o_misalign   = 1'b0;
    o_dm_addr    = w_word_addr;
    o_dm_wdata   = i_wdata;
    o_dm_wpc     = i_pc;
    o_load_data  = 32'h0;
    if (reset) begin
      o_dm_addr  = w_word_addr;
    end else if (r_state == WRITE) begin
      o_dm_write = 1'b1;
      o_dm_wdata = r_merge;
      o_dm_addr  = r_waddr;
      o_dm_wpc   = r_wpc;
    end else if (i_req_valid) begin
      if (w_misaligned) begin
        o_misalign = 1'b1;
      end else begin
        case (i_op)
          OP_LW: begin
            o_dm_read    = 1'b1;
            o_load_valid = 1'b1;
            o_load_data  = i_dm_rdata;
          end
          OP_LH: begin
            o_dm_read    = 1'b1;
            o_load_valid = 1'b1;
            o_load_data  = {{16{w_half_lane[15]}}, w_half_lane[15:0]};
          end
          OP_LHU: begin
            o_dm_read    = 1'b1;
            o_load_valid = 1'b1;
            o_load_data  = {16'h0, w_half_lane[15:0]};
          end
          OP_LB: begin
            o_dm_read    = 1'b1;
            o_load_valid = 1'b1;
            o_load_data  = {{24{w_byte_lane[7]}}, w_byte_lane[7:0]};
          end
          OP_LBU: begin
            o_dm_read    = 1'b1;
            o_load_valid = 1'b1;
            o_load_data  = {24'h0, w_byte_lane[7:0]};
          end
          OP_SW: begin
            o_dm_write = 1'b1;
          end
          default: begin
            o_dm_read = 1'b1;
            o_stall   = 1'b1;
          end
        endcase
      end
    end
  end

  // Reset also abandons a pending merge, so no write leaks out after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_merge        <= 32'h0;
      r_waddr        <= 32'h0;
      r_wpc          <= 32'h0;
      r_misalign_cnt <= 8'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid && w_misaligned) begin
            if (r_misalign_cnt != 8'hFF)
              r_misalign_cnt <= r_misalign_cnt + 8'h1;
          end else if (i_req_valid && w_subword_store) begin
            r_merge <= w_merge;
            r_waddr <= w_word_addr;
            r_wpc   <= i_pc;
            r_state <= WRITE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_misalign_cnt = r_misalign_cnt;

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: expected loads and memory writes are queued at drive time
// and compared by a monitor when the DUT presents them; a word memory model backs the DUT.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic        dmWrite;
  logic        dmRead;
  logic [31:0] dmRdata;
  logic [31:0] dmWpc;
  logic [31:0] loadData;
  logic        loadValid;
  logic        misalign;
  logic [7:0]  misalignCnt;

  logic [31:0] mem [0:63];
  logic [31:0] expLoad [$];
  logic [95:0] expWrite [$];
  int          assertCount = 0;
  int          failCount = 0;

  lsu_align dut (
    .clk(clk), .reset(reset), .i_req_valid(reqValid), .i_op(op), .i_addr(addr),
    .i_wdata(wdata), .i_pc(pc), .o_stall(stall), .o_dm_addr(dmAddr), .o_dm_wdata(dmWdata),
    .o_dm_write(dmWrite), .o_dm_read(dmRead), .i_dm_rdata(dmRdata), .o_dm_wpc(dmWpc),
    .o_load_data(loadData), .o_load_valid(loadValid), .o_misalign(misalign),
    .o_misalign_cnt(misalignCnt)
  );

  always #5 clk = ~clk;

  assign dmRdata = mem[dmAddr[7:2]];

  always @(posedge clk) begin
    if (!reset && dmWrite) mem[dmAddr[7:2]] <= dmWdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic isMisaligned(input logic [2:0] o, input logic [31:0] a);
    if (o == 3'd0 || o == 3'd5) return a[1:0] != 2'b00;
    if (o == 3'd1 || o == 3'd2 || o == 3'd6) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (o)
      3'd1: return {{16{h[15]}}, h};
      3'd2: return {16'h0, h};
      3'd3: return {{24{b[7]}}, b};
      3'd4: return {24'h0, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] modelMerge(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (o == 3'd6) begin
      if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
    end else begin
      case (a[1:0])
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  // Monitor: every load result and memory write must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [95:0] w;
    if (!reset && loadValid) begin
      if (expLoad.size() == 0) checkOutput("unexpectedLoad", loadData, 32'hxxxxxxxx);
      else checkOutput("loadData", loadData, expLoad.pop_front());
    end
    if (!reset && dmWrite) begin
      if (expWrite.size() == 0) checkOutput("unexpectedWrite", dmWdata, 32'hxxxxxxxx);
      else begin
        w = expWrite.pop_front();
        checkOutput("writeAddr", dmAddr, w[95:64]);
        checkOutput("writeData", dmWdata, w[63:32]);
        checkOutput("writePc", dmWpc, w[31:0]);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that completes the request.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] p);
    logic mis, sub;
    logic [31:0] w;
    mis = isMisaligned(o, a);
    sub = (o == 3'd6 || o == 3'd7) && !mis;
    w = mem[a[7:2]];
    reqValid = 1'b1; op = o; addr = a; wdata = d; pc = p;
    if (!mis) begin
      if (o <= 3'd4) expLoad.push_back(modelLoad(o, a, w));
      else if (o == 3'd5) expWrite.push_back({a & 32'hFFFF_FFFC, d, p});
      else expWrite.push_back({a & 32'hFFFF_FFFC, modelMerge(o, a, w, d), p});
    end
    @(negedge clk);
    checkOutput("stall", {31'h0, stall}, {31'h0, sub});
    checkOutput("misalign", {31'h0, misalign}, {31'h0, mis});
    checkOutput("dmRead", {31'h0, dmRead}, {31'h0, !mis && (o != 3'd5)});
    if (mis) begin
      checkOutput("misWrite", {31'h0, dmWrite}, 32'h0);
      checkOutput("misLoadValid", {31'h0, loadValid}, 32'h0);
    end
    @(posedge clk); #1;
    if (sub) begin
      @(negedge clk);
      checkOutput("wrStall", {31'h0, stall}, 32'h0);
      checkOutput("wrWrite", {31'h0, dmWrite}, 32'h1);
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8899AABB;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h11223344;
    mem[16] = 32'h11223344;
    reset = 1'b1; reqValid = 1'b1; op = 3'd0; addr = 32'h11; wdata = 32'h0; pc = 32'h0;

    @(negedge clk);
    checkOutput("rstMisalign", {31'h0, misalign}, 32'h0);
    checkOutput("rstRead", {31'h0, dmRead}, 32'h0);
    checkOutput("rstCnt", {24'h0, misalignCnt}, 32'h0);
    op = 3'd7; addr = 32'h21;
    @(negedge clk);
    checkOutput("rstStall", {31'h0, stall}, 32'h0);
    checkOutput("rstWrite", {31'h0, dmWrite}, 32'h0);
    checkOutput("rstLoadValid", {31'h0, loadValid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; reqValid = 1'b0;
    @(negedge clk);
    checkOutput("idleRead", {31'h0, dmRead}, 32'h0);
    checkOutput("idleStall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;

    applyStimulus(3'd0, 32'h10, 32'h0, 32'h100);
    checkOutput("cntAfterLw", {24'h0, misalignCnt}, 32'h0);
    applyStimulus(3'd3, 32'h13, 32'h0, 32'h104);
    applyStimulus(3'd4, 32'h13, 32'h0, 32'h108);
    applyStimulus(3'd1, 32'h12, 32'h0, 32'h10C);
    applyStimulus(3'd2, 32'h10, 32'h0, 32'h110);
    applyStimulus(3'd7, 32'h21, 32'h123456CD, 32'h114);
    checkOutput("sbMem", mem[8], 32'h1122CD44);
    applyStimulus(3'd0, 32'h20, 32'h0, 32'h118);
    applyStimulus(3'd6, 32'h32, 32'h0000BEEF, 32'h11C);
    checkOutput("shMem", mem[12], 32'hBEEF3344);
    applyStimulus(3'd5, 32'h34, 32'hCAFEF00D, 32'h120);
    checkOutput("swMem", mem[13], 32'hCAFEF00D);
    applyStimulus(3'd0, 32'h11, 32'h0, 32'h124);
    applyStimulus(3'd6, 32'h23, 32'h5555, 32'h128);
    checkOutput("misCnt2", {24'h0, misalignCnt}, 32'h2);
    checkOutput("misMemKept", mem[8], 32'h1122CD44);

    reqValid = 1'b1; op = 3'd0; addr = 32'h11;
    repeat (300) @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    checkOutput("misCntSat", {24'h0, misalignCnt}, 32'hFF);
    @(posedge clk); #1;

    reqValid = 1'b1; op = 3'd7; addr = 32'h41; wdata = 32'hAB; pc = 32'h200;
    @(negedge clk);
    checkOutput("rstSbStall", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstWrWrite", {31'h0, dmWrite}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; reqValid = 1'b0;
    @(negedge clk);
    checkOutput("postRstWrite", {31'h0, dmWrite}, 32'h0);
    checkOutput("postRstMem", mem[16], 32'h11223344);
    @(posedge clk); #1;
    applyStimulus(3'd0, 32'h40, 32'h0, 32'h204);

    repeat (2) @(posedge clk);
    checkOutput("loadQueueEmpty", expLoad.size(), 32'h0);
    checkOutput("writeQueueEmpty", expWrite.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
